enc16to4_pend: RTL and testbench
================================

Name: enc16to4_pend

Overview:
- Sequential 16-to-4 encoder; the encode-side counterpart of the team's 4-to-16 decoder.
- Captures request bits from a 16-bit input into a pending register.
- Emits the 4-bit index of each pending request, one at a time, on a valid/ready handshake, clearing each bit as it is issued.
- Sits upstream of the decoder, so a decoded one-hot line can be regenerated downstream from the index stream.

Parameters:
- WIDTH, 16, number of request lines.
- IDX_W, 4, index width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  capture enable; when 0, in is ignored.
- in  input  WIDTH  request lines, sampled every cycle while en=1.
- ready  input  1  consumer accepts out when valid=1 and ready=1.
- out  output  IDX_W  encoded index of the issued request.
- valid  output  1  out holds a request.
- idle  output  1  pending register all-zero and valid=0.
- dropped  output  1  one-cycle pulse when an incoming bit was already pending.

Behaviour:
- Reset, asynchronous on rst_n=0: pending=0, state=IDLE, out=0, valid=0, idle=1, dropped=0. Reset mid-handshake discards the held index and all pending bits with no partial issue.
- Capture, each clk edge with en=1: pending <= (pending & ~clr_mask) | in.
  - clr_mask is the one-hot bit issued at this same edge.
  - A bit set in in and cleared at the same edge stays pending (set wins).
- With en=0: pending only loses issued bits; no new captures.
- dropped <= 1 for one cycle when en=1 and (in & pending & ~clr_mask) != 0, otherwise 0.
- Selection, fixed priority: highest set index of the registered pending wins (bit 15 highest). in is not looked at until it is registered.
- State machine:
  - IDLE: valid=0. If pending!=0: out <= sel, valid <= 1, that bit is cleared, go to HOLD. Else stay.
  - HOLD: valid=1 and out stable until handshake. On valid & ready, if pending after clearing is nonzero, load the next sel the same edge (back-to-back, no bubble) and stay in HOLD; else valid <= 0 and go to IDLE.
  - ready while in IDLE is ignored.
- Latency: request on in at edge t (en=1) is pending after t and appears on out/valid after edge t+1. Throughput is 1 index per cycle while ready=1.
- idle is combinational: (pending==0) & ~valid.
- A request whose bit is pending again while its index is held in HOLD is issued again later (two handshakes).
- Multiple bits captured in one cycle are issued in descending index order.

Optional Feature:
- ROUND_ROBIN_EN defined:
  - Selection is rotating priority. Search starts at (last issued index - 1) mod WIDTH, descending with wrap-around; the pointer updates on each issue and resets to WIDTH-1.
  - With all 16 bits permanently requested, issue order is 15,14,...,0,15,...
- Not defined: fixed priority as above; no pointer register.

Test Plan:
- Reset then en=0, in=16'h0100 for 3 cycles -> valid=0, idle=1, pending stays 0.
- en=1, in=16'h0004 for 1 cycle, ready=1 -> valid=1, out=2 two edges later, valid=0 the following cycle, idle=1.
- en=1, in=16'h8421 for 1 cycle, ready=1 -> out=15,10,5,0 on 4 consecutive cycles with valid high, then valid=0.
- in=16'h0030 once, ready=0 for 5 cycles then 1 -> out=5 held stable for 5 cycles, then out=4, then idle.
- Hold out=3 with ready=0, drive in=16'h0008 twice -> first capture re-arms bit 3 with dropped=0; second gives dropped=1; index 3 is issued twice in total.
- Assert rst_n=0 mid-HOLD with pending=16'h00F0 -> valid, out, pending zero immediately; with ROUND_ROBIN_EN and in=16'hFFFF held -> order 15,14,...,0,15.

Source files
------------

// File: rtl/enc16to4_pend.sv
// -----------------------------------------------------------------------------
// enc16to4_pend -- sequential 16-to-4 encoder with a pending-request register.
//
// Request bits arriving on `in` (while `en`=1) are captured into a pending
// register. A two-state FSM issues the index of one pending bit at a time on a
// valid/ready handshake and clears that bit as it is issued. The stream of
// indices can be fed to the 4-to-16 decoder downstream to regenerate one-hot
// lines.
//
// Handshake: `out` is offered while `valid`=1 and is held stable until the
// cycle in which `ready`=1; that edge is the transfer. If more requests are
// pending, the next index is loaded on that same edge (no bubble). `ready`
// is ignored while `valid`=0.
//
// Optional build macro:
//   ROUND_ROBIN_EN  rotating-priority selection (search starts one below the
//                   last issued index, descending, wrapping). Undefined:
//                   fixed priority, highest set index wins.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   en       in   capture enable for `in`
//   in       in   WIDTH request lines
//   ready    in   consumer accepts `out` when valid & ready
//   out      out  IDX_W issued index
//   valid    out  `out` holds a request
//   idle     out  pending register empty and nothing offered (combinational)
//   dropped  out  one-cycle pulse: an incoming bit was already pending
//   state_o  out  debug view of the FSM state (0 = IDLE, 1 = HOLD)
// -----------------------------------------------------------------------------
module enc16to4_pend #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] in,
   input  logic             ready,
   output logic [IDX_W-1:0] out,
   output logic             valid,
   output logic             idle,
   output logic             dropped,
   output logic             state_o
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [IDX_W-1:0] out_q;
   logic             valid_q;
   logic             dropped_q, dropped_d;

   logic [IDX_W-1:0] sel;
   logic             issue;
   logic [WIDTH-1:0] clr_mask;

`ifdef ROUND_ROBIN_EN
   // Search start point for the rotating priority; reset so the first search
   // begins at the top index.
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] rr_idx;

   // Walk from the farthest candidate towards ptr_q so the candidate closest
   // to ptr_q (in descending, wrapping order) is the last to overwrite sel.
   always_comb begin
      sel    = '0;
      rr_idx = '0;
      for (int k = WIDTH - 1; k >= 0; k--) begin
         rr_idx = ptr_q - IDX_W'(k);
         if (pending_q[rr_idx]) begin
            sel = rr_idx;
         end
      end
   end
`else
   // Fixed priority: ascending scan, so the highest set index is kept.
   always_comb begin
      sel = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (pending_q[i]) begin
            sel = IDX_W'(i);
         end
      end
   end
`endif

   // An index is issued when something is pending and the output slot is
   // free (IDLE) or being vacated this edge (HOLD with ready). In HOLD the
   // held bit was already cleared, so pending_q is "pending after clearing".
   always_comb begin
      issue     = (|pending_q) & ((state_q == ST_IDLE) | ready);
      clr_mask  = issue ? (WIDTH'(1) << sel) : '0;
      // Clear first, then OR in new requests: a bit re-requested on the edge
      // it is issued stays pending.
      pending_d = (pending_q & ~clr_mask) | (en ? in : '0);
      dropped_d = en & (|(in & pending_q & ~clr_mask));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         out_q     <= '0;
         valid_q   <= 1'b0;
         dropped_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
         ptr_q     <= IDX_W'(WIDTH - 1);
`endif
      end else begin
         pending_q <= pending_d;
         dropped_q <= dropped_d;
`ifdef ROUND_ROBIN_EN
         if (issue) begin
            ptr_q <= sel - 1'b1;
         end
`endif
         case (state_q)
            ST_IDLE: begin
               if (issue) begin
                  out_q   <= sel;
                  valid_q <= 1'b1;
                  state_q <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (ready) begin
                  if (issue) begin
                     out_q <= sel;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign out     = out_q;
   assign valid   = valid_q;
   assign dropped = dropped_q;
   assign idle    = (pending_q == '0) & ~valid_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_enc16to4_pend.sv
// -----------------------------------------------------------------------------
// Testbench for enc16to4_pend. A behavioural model tracks the set of pending
// requests and the offered index; handshakes seen on the DUT are also logged
// and compared against directed index sequences.
// -----------------------------------------------------------------------------
module tb_enc16to4_pend;

   logic        clk;
   logic        rst_n;
   logic        tb_en;
   logic [15:0] tb_in;
   logic        tb_ready;
   logic [3:0]  out;
   logic        valid;
   logic        idle;
   logic        dropped;
   logic        state_o;

   int n_vec = 0;
   int n_err = 0;

   // Model state
   logic [15:0] m_pend;
   logic        m_valid;
   logic [3:0]  m_out;
   logic        m_drop;
   int          m_ptr;

   // Indices transferred by the DUT (valid & ready observed before an edge)
   logic [3:0]  hs_q[$];
   logic [3:0]  exp_q[$];

   enc16to4_pend dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (tb_en),
      .in      (tb_in),
      .ready   (tb_ready),
      .out     (out),
      .valid   (valid),
      .idle    (idle),
      .dropped (dropped),
      .state_o (state_o)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   function automatic int pick(input logic [15:0] p, input int ptr);
      int r;
      r = 0;
`ifdef ROUND_ROBIN_EN
      for (int k = 15; k >= 0; k--) begin
         if (p[(ptr - k + 16) % 16]) r = (ptr - k + 16) % 16;
      end
`else
      for (int i = 0; i < 16; i++) begin
         if (p[i]) r = i;
      end
`endif
      return r;
   endfunction

   task automatic model_reset();
      m_pend  = '0;
      m_valid = 1'b0;
      m_out   = '0;
      m_drop  = 1'b0;
      m_ptr   = 15;
   endtask

   // One clock: log handshake, advance model, clock, compare outputs.
   task automatic step(input string tag);
      int          s;
      logic        iss;
      logic [15:0] clr;
      logic        m_idle;
      if (valid && tb_ready) hs_q.push_back(out);
      iss    = (!m_valid || tb_ready) && (m_pend != 0);
      s      = pick(m_pend, m_ptr);
      clr    = iss ? (16'h1 << s) : 16'h0;
      m_drop = tb_en && ((tb_in & m_pend & ~clr) != 0);
      m_pend = (m_pend & ~clr) | (tb_en ? tb_in : 16'h0);
      if (iss) begin
         m_out   = s[3:0];
         m_valid = 1'b1;
         m_ptr   = (s + 15) % 16;
      end else if (m_valid && tb_ready) begin
         m_valid = 1'b0;
      end
      m_idle = (m_pend == 0) && !m_valid;
      @(posedge clk);
      #1;
      n_vec++;
      if (valid !== m_valid) begin
         n_err++;
         $display("FAIL %s valid: got %b expected %b", tag, valid, m_valid);
      end
      n_vec++;
      if (idle !== m_idle) begin
         n_err++;
         $display("FAIL %s idle: got %b expected %b", tag, idle, m_idle);
      end
      n_vec++;
      if (dropped !== m_drop) begin
         n_err++;
         $display("FAIL %s dropped: got %b expected %b", tag, dropped, m_drop);
      end
      if (m_valid) begin
         n_vec++;
         if (out !== m_out) begin
            n_err++;
            $display("FAIL %s out: got %0d expected %0d", tag, out, m_out);
         end
      end
   endtask

   task automatic check_hs(input string tag);
      n_vec++;
      if (hs_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL %s handshake count: got %0d expected %0d", tag, hs_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            if (hs_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL %s handshake[%0d]: got %0d expected %0d", tag, i, hs_q[i], exp_q[i]);
            end
         end
      end
      hs_q.delete();
      exp_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; tb_en = 1'b0; tb_in = '0; tb_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (valid !== 1'b0 || out !== 4'd0 || idle !== 1'b1 || dropped !== 1'b0) begin
         n_err++;
         $display("FAIL reset: got valid=%b out=%0d idle=%b dropped=%b expected 0 0 1 0",
                  valid, out, idle, dropped);
      end
      @(negedge clk);
      rst_n = 1'b1;
      hs_q.delete();
   endtask

   task automatic test_en_low();
      tb_en = 1'b0; tb_in = 16'h0100; tb_ready = 1'b1;
      repeat (3) step("en_low");
      tb_in = '0;
      step("en_low_tail");
      check_hs("en_low");
   endtask

   task automatic test_single();
      tb_en = 1'b1; tb_in = 16'h0004; tb_ready = 1'b1;
      step("single_cap");
      tb_en = 1'b0; tb_in = '0;
      step("single_issue");
      n_vec++;
      if (valid !== 1'b1 || out !== 4'd2) begin
         n_err++;
         $display("FAIL single direct: got valid=%b out=%0d expected 1 2", valid, out);
      end
      repeat (2) step("single_drain");
      exp_q = '{4'd2};
      check_hs("single");
   endtask

   task automatic test_back_to_back();
      tb_en = 1'b1; tb_in = 16'h8421; tb_ready = 1'b1;
      step("b2b_cap");
      tb_en = 1'b0; tb_in = '0;
      repeat (6) step("b2b");
      exp_q = '{4'd15, 4'd10, 4'd5, 4'd0};
      check_hs("b2b");
   endtask

   task automatic test_stall();
      tb_en = 1'b1; tb_in = 16'h0030; tb_ready = 1'b0;
      step("stall_cap");
      tb_en = 1'b0; tb_in = '0;
      repeat (5) step("stall_hold");
      n_vec++;
      if (out !== 4'd5) begin
         n_err++;
         $display("FAIL stall direct: got out=%0d expected 5", out);
      end
      tb_ready = 1'b1;
      repeat (3) step("stall_drain");
      exp_q = '{4'd5, 4'd4};
      check_hs("stall");
   endtask

   task automatic test_rearm();
      tb_en = 1'b1; tb_in = 16'h0008; tb_ready = 1'b0;
      step("rearm_cap");
      tb_en = 1'b0; tb_in = '0;
      step("rearm_issue");
      tb_en = 1'b1; tb_in = 16'h0008;
      step("rearm_first");
      n_vec++;
      if (dropped !== 1'b0) begin
         n_err++;
         $display("FAIL rearm first dropped: got %b expected 0", dropped);
      end
      step("rearm_second");
      n_vec++;
      if (dropped !== 1'b1) begin
         n_err++;
         $display("FAIL rearm second dropped: got %b expected 1", dropped);
      end
      tb_en = 1'b0; tb_in = '0; tb_ready = 1'b1;
      repeat (4) step("rearm_drain");
      exp_q = '{4'd3, 4'd3};
      check_hs("rearm");
   endtask

   task automatic test_reset_mid();
      tb_en = 1'b1; tb_in = 16'h01F0; tb_ready = 1'b0;
      step("rmid_cap");
      tb_en = 1'b0; tb_in = '0;
      step("rmid_hold");
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (valid !== 1'b0 || out !== 4'd0 || idle !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid: got valid=%b out=%0d idle=%b expected 0 0 1", valid, out, idle);
      end
      model_reset();
      hs_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tb_ready = 1'b1;
      repeat (3) step("rmid_after");
      check_hs("reset_mid");
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         tb_en    = ($urandom_range(0, 3) != 0);
         tb_in    = 16'($urandom) & 16'($urandom) & 16'($urandom);
         tb_ready = ($urandom_range(0, 2) != 0);
         step("random");
      end
      tb_en = 1'b0; tb_in = '0; tb_ready = 1'b1;
      repeat (20) step("random_drain");
      hs_q.delete();
   endtask

`ifdef ROUND_ROBIN_EN
   task automatic test_round_robin();
      #2 rst_n = 1'b0;
      #1 model_reset();
      hs_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tb_en = 1'b1; tb_in = 16'hFFFF; tb_ready = 1'b1;
      repeat (19) step("rr");
      for (int i = 15; i >= 0; i--) exp_q.push_back(4'(i));
      exp_q.push_back(4'd15);
      while (hs_q.size() > exp_q.size()) void'(hs_q.pop_back());
      check_hs("round_robin");
      tb_en = 1'b0; tb_in = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_en_low();
      test_single();
      test_back_to_back();
      test_stall();
      test_rearm();
      test_reset_mid();
      test_random();
`ifdef ROUND_ROBIN_EN
      test_round_robin();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
